// File: rtl/reg_dump_sequencer_if.sv
// Bundle between the dump sequencer, the CPU control FSM, the register-file
// debug port and ascii_master_controller.
interface reg_dump_sequencer_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [4:0]  debug_reg;
  logic [31:0] debug_reg_data;
  // Cell write handshake: ascii_write_en is the valid. While it is high,
  // address and data stay frozen. The write is taken at the first rising
  // edge where ascii_ready is also high.
  logic        ascii_write_en;
  logic [12:0] ascii_write_address;
  logic [31:0] ascii_input;
  logic        ascii_ready;

  modport master (
    input  start, debug_reg_data, ascii_ready,
    output busy, done, debug_reg, ascii_write_en, ascii_write_address, ascii_input
  );

  modport slave (
    output start, debug_reg_data, ascii_ready,
    input  busy, done, debug_reg, ascii_write_en, ascii_write_address, ascii_input
  );
endinterface

// File: rtl/reg_dump_sequencer.sv
// Walks the register-file debug port and writes each register as 8 hex ASCII
// cells, one screen row per register. Define REG_DUMP_LABEL_EN to add an "xNN:" label per row.
module reg_dump_sequencer #(
  parameter int          NUM_REGS     = 32,
  parameter int          COLS         = 80,
  parameter int          BASE_ADDR    = 0,
  parameter int          READ_LATENCY = 1,
  parameter logic [23:0] ATTR         = 24'hFFFFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  reg_dump_sequencer_if.master bus,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_WAIT, S_CAPTURE, S_EMIT, S_NEXT, S_DONE
  } state_t;

`ifdef REG_DUMP_LABEL_EN
  localparam int NCHARS = 12;
`else
  localparam int NCHARS = 8;
`endif

  localparam logic [2:0] LAT_LOAD   = 3'(READ_LATENCY);
  localparam logic [4:0] LAST_IDX   = 5'(NUM_REGS - 1);
  localparam logic [3:0] LAST_COL   = 4'(NCHARS - 1);
  localparam state_t     LOAD_STATE = (READ_LATENCY == 0) ? S_CAPTURE : S_RD_WAIT;

  state_t      state, state_n;
  logic [4:0]  reg_idx;
  logic [3:0]  col;
  logic [2:0]  lat_cnt;
  logic [31:0] shreg;
  logic        in_hex;
  logic [7:0]  hex_ch;
  logic [7:0]  cell_ch;
  logic        emit;

  assign emit = (state == S_EMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:    if (bus.start) state_n = LOAD_STATE;
      S_RD_WAIT: if (lat_cnt <= 3'd1) state_n = S_CAPTURE;
      S_CAPTURE: state_n = S_EMIT;
      S_EMIT:    if (bus.ascii_ready && (col == LAST_COL)) state_n = S_NEXT;
      S_NEXT:    state_n = (reg_idx == LAST_IDX) ? S_DONE : LOAD_STATE;
      S_DONE:    state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_idx <= '0;
      col     <= '0;
      lat_cnt <= '0;
      shreg   <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.start) begin
          reg_idx <= '0;
          lat_cnt <= LAT_LOAD;
        end
        S_RD_WAIT: lat_cnt <= lat_cnt - 3'd1;
        S_CAPTURE: begin
          shreg <= bus.debug_reg_data;
          col   <= '0;
        end
        // The current nibble always sits in shreg[31:28]. It shifts out only
        // once its hex cell has been accepted.
        S_EMIT: if (bus.ascii_ready) begin
          col <= col + 4'd1;
          if (in_hex) shreg <= {shreg[27:0], 4'h0};
        end
        S_NEXT: if (reg_idx != LAST_IDX) begin
          reg_idx <= reg_idx + 5'd1;
          lat_cnt <= LAT_LOAD;
        end
        default: ;
      endcase
    end
  end

  assign hex_ch = (shreg[31:28] < 4'd10) ? (8'h30 + {4'h0, shreg[31:28]})
                                         : (8'h37 + {4'h0, shreg[31:28]});

`ifdef REG_DUMP_LABEL_EN
  logic [1:0] tens;
  logic [4:0] ones;
  logic [7:0] label_ch;

  assign in_hex = (col >= 4'd4);

  always_comb begin
    tens = 2'd0;
    ones = reg_idx;
    if (reg_idx >= 5'd30) begin
      tens = 2'd3;
      ones = reg_idx - 5'd30;
    end else if (reg_idx >= 5'd20) begin
      tens = 2'd2;
      ones = reg_idx - 5'd20;
    end else if (reg_idx >= 5'd10) begin
      tens = 2'd1;
      ones = reg_idx - 5'd10;
    end
  end

  always_comb begin
    label_ch = 8'h78;
    case (col[1:0])
      2'd0: label_ch = 8'h78;
      2'd1: label_ch = 8'h30 + {6'd0, tens};
      2'd2: label_ch = 8'h30 + {3'd0, ones};
      2'd3: label_ch = 8'h3A;
      default: label_ch = 8'h78;
    endcase
  end

  assign cell_ch = in_hex ? hex_ch : label_ch;
`else
  assign in_hex  = 1'b1;
  assign cell_ch = hex_ch;
`endif

  assign bus.busy           = (state != S_IDLE);
  assign bus.done           = (state == S_DONE);
  assign bus.debug_reg      = reg_idx;
  assign bus.ascii_write_en = emit;
  // The cell address is formed at 13 bits on purpose, so it wraps at the end of cell space.
  assign bus.ascii_write_address = emit ?
    (13'(BASE_ADDR) + 13'(reg_idx) * 13'(COLS) + {9'd0, col}) : 13'd0;
  assign bus.ascii_input = emit ? {cell_ch, ATTR} : 32'd0;
  assign dbg_state       = state;

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// Scoreboard bench for reg_dump_sequencer. A queue-based reference model
// predicts every cell write, and a negedge monitor checks the DUT against it.
module tb_reg_dump_sequencer;
  localparam int          NUM_REGS     = 32;
  localparam int          COLS         = 80;
  localparam int          BASE_ADDR    = 8150;
  localparam int          READ_LATENCY = 2;
  localparam logic [23:0] ATTR         = 24'hC3A55A;
`ifdef REG_DUMP_LABEL_EN
  localparam int NCH = 12;
`else
  localparam int NCH = 8;
`endif
  localparam int PER_REG  = READ_LATENCY + NCH + 2;
  localparam int PIPE_IDX = (READ_LATENCY == 0) ? 0 : READ_LATENCY - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] dbg_state;

  reg_dump_sequencer_if bus ();

  reg_dump_sequencer #(
    .NUM_REGS(NUM_REGS), .COLS(COLS), .BASE_ADDR(BASE_ADDR),
    .READ_LATENCY(READ_LATENCY), .ATTR(ATTR)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Register file model with a READ_LATENCY-deep read pipe
  logic [31:0] regs    [0:31];
  logic [31:0] rf_pipe [0:7];
  always @(posedge clk) begin
    rf_pipe[0] <= regs[bus.debug_reg];
    for (int i = 1; i < 8; i++) rf_pipe[i] <= rf_pipe[i-1];
  end
  assign bus.debug_reg_data = (READ_LATENCY == 0) ? regs[bus.debug_reg] : rf_pipe[PIPE_IDX];

  int  cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int  n_checks = 0;
  int  n_errors = 0;
  int  start_cyc = 0;
  int  stall_base = 0;
  int  stalls = 0;
  bit  rand_ready = 1'b0;
  logic [44:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the whole dump's cell writes, in order, from the register contents
  function automatic void push_dump();
    string       hex_digits;
    int          addr;
    int          k;
    int          nib;
    logic [7:0]  ch;
    hex_digits = "0123456789ABCDEF";
    for (int r = 0; r < NUM_REGS; r++) begin
      for (int c = 0; c < NCH; c++) begin
        addr = (BASE_ADDR + r * COLS + c) % 8192;
        k    = c - (NCH - 8);
        ch   = "x";
        if (k >= 0) begin
          nib = int'((regs[r] >> (28 - 4 * k)) & 32'hF);
          ch  = hex_digits[nib];
        end else if (c == 1) begin
          ch = 8'("0" + r / 10);
        end else if (c == 2) begin
          ch = 8'("0" + r % 10);
        end else if (c == 3) begin
          ch = ":";
        end
        exp_q.push_back({13'(addr), ch, ATTR});
      end
    end
  endfunction

  // ascii_ready driver
  initial begin
    bus.ascii_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.ascii_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: pops one expected cell per accepted write, checks hold and done timing
  initial begin
    logic        hold_v;
    logic        prev_done;
    logic [44:0] held;
    logic [44:0] got;
    logic [44:0] e;
    hold_v    = 1'b0;
    prev_done = 1'b0;
    held      = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold_v    = 1'b0;
        prev_done = 1'b0;
      end else begin
        got = {bus.ascii_write_address, bus.ascii_input};
        if (hold_v) begin
          check("hold_en", 64'(bus.ascii_write_en), 64'd1);
          check("hold_stable", 64'(got), 64'(held));
        end
        if (bus.ascii_write_en) begin
          check("en_implies_busy", 64'(bus.busy), 64'd1);
          if (bus.ascii_ready) begin
            if (exp_q.size() == 0) begin
              n_checks++;
              n_errors++;
              $display("FAIL unexpected_write: addr %0d data %0h, none expected", got[44:32], got[31:0]);
            end else begin
              e = exp_q.pop_front();
              check("write_addr", 64'(got[44:32]), 64'(e[44:32]));
              check("write_data", 64'(got[31:0]), 64'(e[31:0]));
            end
          end else begin
            stalls++;
          end
        end
        hold_v = bus.ascii_write_en && !bus.ascii_ready;
        held   = got;
        if (bus.done) begin
          check("done_single", 64'(prev_done), 64'd0);
          check("done_cycle", 64'(cyc - start_cyc), 64'(NUM_REGS * PER_REG + (stalls - stall_base)));
          check("done_queue_empty", 64'(exp_q.size()), 64'd0);
          check("done_busy", 64'(bus.busy), 64'd1);
        end
        prev_done = bus.done;
      end
    end
  end

  task automatic start_dump();
    check("idle_before_start", 64'(bus.busy), 64'd0);
    bus.start = 1'b1;
    push_dump();
    @(posedge clk);
    #1;
    start_cyc  = cyc;
    stall_base = stalls;
    bus.start  = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.done && k < 3000);
    check("done_seen", 64'(bus.done), 64'd1);
    if (!bus.done) exp_q.delete();
    @(negedge clk);
    check("idle_after_done", 64'({bus.busy, bus.done}), 64'd0);
  endtask

  task automatic randomize_regs();
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, 64'({bus.busy, bus.done, bus.ascii_write_en, bus.debug_reg}), 64'd0);
    check(name, 64'({bus.ascii_write_address, bus.ascii_input}), 64'd0);
    check(name, 64'(dbg_state), 64'd0);
  endtask

  initial begin
    int k;
    bus.start = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    regs[1] = 32'hDEADBEEF;

    // Reset state
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_outputs");
    rst = 1'b1;
    @(negedge clk);

    // Dump 1: ready tied high, with a stray start pulse mid-dump
    rand_ready = 1'b0;
    start_dump();
    repeat (99) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();

    // Dump 2: random data, random backpressure
    randomize_regs();
    rand_ready = 1'b1;
    @(negedge clk);
    start_dump();
    wait_done();

    // Dumps 3+4: start held high across done
    randomize_regs();
    @(negedge clk);
    check("idle_before_start", 64'(bus.busy), 64'd0);
    bus.start = 1'b1;
    push_dump();
    @(posedge clk);
    #1;
    start_cyc  = cyc;
    stall_base = stalls;
    wait_done();
    @(posedge clk);
    #1;
    start_cyc  = cyc;
    stall_base = stalls;
    push_dump();
    bus.start = 1'b0;
    @(negedge clk);
    check("restart_busy", 64'(bus.busy), 64'd1);
    wait_done();

    // Reset during register 5's emit
    randomize_regs();
    @(negedge clk);
    start_dump();
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(bus.debug_reg == 5'd5 && bus.ascii_write_en) && k < 3000);
    check("reached_reg5", 64'(bus.debug_reg), 64'd5);
    #2;
    rst = 1'b0;
    #1;
    check_outputs_zero("async_reset_outputs");
    exp_q.delete();
    repeat (3) @(negedge clk);
    check_outputs_zero("held_reset_outputs");
    rst = 1'b1;
    repeat (30) begin
      @(negedge clk);
      check("idle_after_reset", 64'({bus.busy, bus.ascii_write_en}), 64'd0);
    end

    // Fresh dump after reset
    randomize_regs();
    start_dump();
    wait_done();

    repeat (5) @(negedge clk);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
